// File: rtl/serial_alu_pkg.sv
// Shared types and slice encodings for the bit-serial ALU sequencer.
// Arithmetic ops pick x = a or ~a and y = b, ~b, 0 or 1, then compute x + y + cin.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_W = 8;

    // mode == 0 (arithmetic)
    localparam logic [2:0] OPSEL_ADD    = 3'd0;  // a + b + cin
    localparam logic [2:0] OPSEL_SUB    = 3'd1;  // a + ~b + cin
    localparam logic [2:0] OPSEL_INC    = 3'd2;  // a + cin
    localparam logic [2:0] OPSEL_DEC    = 3'd3;  // a + all-ones + cin
    localparam logic [2:0] OPSEL_RSUB   = 3'd4;  // ~a + b + cin
    localparam logic [2:0] OPSEL_NSUB   = 3'd5;  // ~a + ~b + cin
    localparam logic [2:0] OPSEL_NEG    = 3'd6;  // ~a + cin
    localparam logic [2:0] OPSEL_NOTDEC = 3'd7;  // ~a + all-ones + cin

    // mode == 1 (logic)
    localparam logic [2:0] OPSEL_AND    = 3'd0;
    localparam logic [2:0] OPSEL_OR     = 3'd1;
    localparam logic [2:0] OPSEL_XOR    = 3'd2;
    localparam logic [2:0] OPSEL_NOR    = 3'd3;
    localparam logic [2:0] OPSEL_NAND   = 3'd4;
    localparam logic [2:0] OPSEL_XNOR   = 3'd5;
    localparam logic [2:0] OPSEL_PASSA  = 3'd6;
    localparam logic [2:0] OPSEL_NOTA   = 3'd7;

    function automatic logic logic_bit(input logic [2:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OPSEL_AND:   r = a & b;
            OPSEL_OR:    r = a | b;
            OPSEL_XOR:   r = a ^ b;
            OPSEL_NOR:   r = ~(a | b);
            OPSEL_NAND:  r = ~(a & b);
            OPSEL_XNOR:  r = ~(a ^ b);
            OPSEL_PASSA: r = a;
            default:     r = ~a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/CarryOut_Result1bitALU.sv
// One-bit ALU slice: full adder with operand conditioning, plus a logic unit.
// In logic mode the carry input is passed straight through to cout.
module CarryOut_Result1bitALU
    import serial_alu_pkg::*;
(
    input  logic       OP1,
    input  logic       OP2,
    input  logic       cin,
    input  logic [2:0] opsel,
    input  logic       mode,
    output logic       result,
    output logic       cout
);

    logic x, y;

    always_comb begin
        x = opsel[2] ? ~OP1 : OP1;
        case (opsel[1:0])
            2'b00:   y = OP2;
            2'b01:   y = ~OP2;
            2'b10:   y = 1'b0;
            default: y = 1'b1;
        endcase

        if (mode) begin
            result = logic_bit(opsel, OP1, OP2);
            cout   = cin;
        end else begin
            result = x ^ y ^ cin;
            cout   = (x & y) | (cin & (x ^ y));
        end
    end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial driver around one CarryOut_Result1bitALU slice, LSB first, W+2 cycles per op.
// Define SERIAL_ALU_OVF_EN to add the signed-overflow output.
module serial_alu_sequencer
    import serial_alu_pkg::*;
#(
    parameter int W = DEFAULT_W
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin0,
    input  logic [2:0]   opsel,
    input  logic         mode,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         zero
`ifdef SERIAL_ALU_OVF_EN
    ,
    output logic         overflow
`endif
);

    localparam int              CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(W - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, b_q, res_q, res_d, result_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    opsel_q;
    logic          mode_q, carry_q, carry_out_q, zero_q;
    logic          slice_res, slice_cout, last_bit;
`ifdef SERIAL_ALU_OVF_EN
    logic          cin_msb_q, overflow_q;
`endif

    assign last_bit = (cnt_q == CNT_LAST);

    CarryOut_Result1bitALU u_slice (
        .OP1    (a_q[0]),
        .OP2    (b_q[0]),
        .cin    (carry_q),
        .opsel  (opsel_q),
        .mode   (mode_q),
        .result (slice_res),
        .cout   (slice_cout)
    );

    generate
        if (W == 1) begin : g_res_w1
            assign res_d = slice_res;
        end else begin : g_res_wn
            assign res_d = {slice_res, res_q[W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // The new word is shown straight from the shift register during DONE,
    // then the held copy takes over until the next completion.
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        result    = result_q;
        carry_out = carry_out_q;
        zero      = zero_q;
`ifdef SERIAL_ALU_OVF_EN
        overflow  = overflow_q;
`endif
        if (state_q == DONE) begin
            result    = res_q;
            carry_out = carry_q;
            zero      = ~|res_q;
`ifdef SERIAL_ALU_OVF_EN
            overflow  = ~mode_q & (cin_msb_q ^ carry_q);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            opsel_q     <= '0;
            mode_q      <= 1'b0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            cin_msb_q   <= 1'b0;
            overflow_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        res_q   <= '0;
                        carry_q <= cin0;
                        opsel_q <= opsel;
                        mode_q  <= mode;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_d;
                    carry_q <= slice_cout;
                    if (!last_bit) cnt_q <= cnt_q + 1'b1;
`ifdef SERIAL_ALU_OVF_EN
                    if (last_bit) cin_msb_q <= carry_q;
`endif
                end
                DONE: begin
                    result_q    <= res_q;
                    carry_out_q <= carry_q;
                    zero_q      <= ~|res_q;
`ifdef SERIAL_ALU_OVF_EN
                    overflow_q  <= ~mode_q & (cin_msb_q ^ carry_q);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer: W=8 instance plus a W=1 instance.
// Overflow checks are compiled in only when SERIAL_ALU_OVF_EN is defined.
module tb_serial_alu_sequencer;
    import serial_alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] op_a = '0, op_b = '0;
    logic       cin0 = 1'b0;
    logic [2:0] opsel = '0;
    logic       mode = 1'b0;
    logic       busy, done, carry_out, zero;
    logic [7:0] result;
`ifdef SERIAL_ALU_OVF_EN
    logic       overflow;
`endif

    logic       s1_start = 1'b0;
    logic [0:0] s1_a = '0, s1_b = '0, s1_result;
    logic       s1_cin0 = 1'b0;
    logic       s1_busy, s1_done, s1_carry_out, s1_zero;
`ifdef SERIAL_ALU_OVF_EN
    logic       s1_overflow;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_alu_sequencer #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .cin0(cin0), .opsel(opsel), .mode(mode), .busy(busy), .done(done),
        .result(result), .carry_out(carry_out), .zero(zero)
`ifdef SERIAL_ALU_OVF_EN
        , .overflow(overflow)
`endif
    );

    serial_alu_sequencer #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .op_a(s1_a), .op_b(s1_b),
        .cin0(s1_cin0), .opsel(OPSEL_ADD), .mode(1'b0), .busy(s1_busy), .done(s1_done),
        .result(s1_result), .carry_out(s1_carry_out), .zero(s1_zero)
`ifdef SERIAL_ALU_OVF_EN
        , .overflow(s1_overflow)
`endif
    );

    // Launch one op on the W=8 DUT; lat counts cycles from the start cycle to done (-1 on timeout).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [2:0] op, input logic m,
                          output int lat, output logic busy_ok);
        @(posedge clk); #1;
        op_a = a; op_b = b; cin0 = c; opsel = op; mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op_a = 'x; op_b = 'x;
        lat = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end while (done !== 1'b1 && lat < 40);
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, carry_out, zero, result} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: busy/done/cout/zero/result = %b%b%b%b %h, want 0000 00",
                     busy, done, carry_out, zero, result);
        end
        checks++;
        if ({s1_busy, s1_done, s1_carry_out, s1_zero, s1_result} !== 5'b0) begin
            errors++;
            $display("FAIL reset_w1: %b%b%b%b%b want 00000", s1_busy, s1_done, s1_carry_out, s1_zero, s1_result);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat; logic bok;
        run_op(8'h3C, 8'h55, 1'b0, OPSEL_ADD, 1'b0, lat, bok);
        checks++;
        if (lat != 9) begin errors++; $display("FAIL add_latency: got %0d want 9", lat); end
        checks++;
        if (bok !== 1'b1) begin errors++; $display("FAIL add_busy: busy dropped before done"); end
        checks++;
        if ({result, carry_out, zero} !== {8'h91, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_result: got %h c=%b z=%b want 91 c=0 z=0", result, carry_out, zero);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++; $display("FAIL add_pulse: done=%b busy=%b after DONE, want 0 0", done, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (result !== 8'h91) begin errors++; $display("FAIL add_hold: got %h want 91", result); end
    endtask

    task automatic test_wrap();
        int lat; logic bok;
        run_op(8'hFF, 8'h01, 1'b0, OPSEL_ADD, 1'b0, lat, bok);
        checks++;
        if ({result, carry_out, zero} !== {8'h00, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL wrap_ff: got %h c=%b z=%b want 00 c=1 z=1", result, carry_out, zero);
        end
`ifdef SERIAL_ALU_OVF_EN
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf0: got %b want 0", overflow); end
`endif
        run_op(8'h7F, 8'h01, 1'b0, OPSEL_ADD, 1'b0, lat, bok);
        checks++;
        if ({result, carry_out, zero} !== {8'h80, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL wrap_7f: got %h c=%b z=%b want 80 c=0 z=0", result, carry_out, zero);
        end
`ifdef SERIAL_ALU_OVF_EN
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL wrap_ovf1: got %b want 1", overflow); end
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b want 1", overflow); end
`endif
    endtask

    task automatic test_arith();
        logic [7:0] a_t [4] = '{8'h50, 8'h10, 8'h00, 8'h01};
        logic [7:0] b_t [4] = '{8'h20, 8'h30, 8'h00, 8'h00};
        logic       c_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0] o_t [4] = '{OPSEL_SUB, OPSEL_RSUB, OPSEL_DEC, OPSEL_NEG};
        logic [7:0] r_t [4] = '{8'h30, 8'h20, 8'hFF, 8'hFF};
        logic       co_t[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int lat; logic bok;
        for (int i = 0; i < 4; i++) begin
            run_op(a_t[i], b_t[i], c_t[i], o_t[i], 1'b0, lat, bok);
            checks++;
            if ({result, carry_out} !== {r_t[i], co_t[i]}) begin
                errors++;
                $display("FAIL arith_op%0d: got %h c=%b want %h c=%b", o_t[i], result, carry_out, r_t[i], co_t[i]);
            end
        end
    endtask

    task automatic test_busy_reject();
        int done_cnt = 0, first_done = 0;
        logic early_drop = 1'b0;
        logic [7:0] r_at_done = '0;
        @(posedge clk); #1;
        op_a = 8'h22; op_b = 8'h33; cin0 = 1'b0; opsel = OPSEL_ADD; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc <= 9 && busy !== 1'b1) early_drop = 1'b1;
            if (done === 1'b1) begin
                done_cnt++;
                if (first_done == 0) begin first_done = cyc; r_at_done = result; end
                op_a = 8'h11; op_b = 8'h11; start = 1'b1;
            end
            if (cyc == 4) begin op_a = 8'h11; op_b = 8'h00; start = 1'b1; end
        end
        checks++;
        if (first_done != 9 || r_at_done !== 8'h55) begin
            errors++;
            $display("FAIL busy_result: done at %0d result %h, want 9 and 55", first_done, r_at_done);
        end
        checks++;
        if (early_drop) begin errors++; $display("FAIL busy_early: busy low before done"); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL busy_pulses: got %0d done pulses want 1", done_cnt); end
        checks++;
        if ({busy, result} !== {1'b0, 8'h55}) begin
            errors++; $display("FAIL busy_after: busy=%b result=%h want 0 55", busy, result);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic bok;
        @(posedge clk); #1;
        op_a = 8'hFF; op_b = 8'hFF; cin0 = 1'b1; opsel = OPSEL_ADD; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, carry_out, zero, result} !== 12'h000) begin
            errors++;
            $display("FAIL midreset_outputs: %b%b%b%b %h want 0000 00", busy, done, carry_out, zero, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h0F, 8'h01, 1'b0, OPSEL_ADD, 1'b0, lat, bok);
        checks++;
        if ({result, carry_out, zero} !== {8'h10, 1'b0, 1'b0} || lat != 9) begin
            errors++;
            $display("FAIL midreset_fresh: got %h c=%b z=%b lat=%0d want 10 0 0 9", result, carry_out, zero, lat);
        end
    endtask

    task automatic test_logic_sweep();
        logic [7:0] a_t [8] = '{8'hA5, 8'h3C, 8'hF0, 8'h81, 8'h5A, 8'hC3, 8'h96, 8'h0F};
        logic [7:0] b_t [8] = '{8'h5F, 8'h42, 8'h33, 8'h7E, 8'hA5, 8'h18, 8'h69, 8'hFF};
        logic [7:0] exp_r [8];
        int lat; logic bok;
        exp_r[0] = a_t[0] & b_t[0];
        exp_r[1] = a_t[1] | b_t[1];
        exp_r[2] = a_t[2] ^ b_t[2];
        exp_r[3] = ~(a_t[3] | b_t[3]);
        exp_r[4] = ~(a_t[4] & b_t[4]);
        exp_r[5] = ~(a_t[5] ^ b_t[5]);
        exp_r[6] = a_t[6];
        exp_r[7] = ~a_t[7];
        for (int i = 0; i < 8; i++) begin
            run_op(a_t[i], b_t[i], i[0], 3'(i), 1'b1, lat, bok);
            checks++;
            if ({result, carry_out, zero, lat, bok} !== {exp_r[i], i[0], (exp_r[i] == 8'h00), 32'd9, 1'b1}) begin
                errors++;
                $display("FAIL logic_op%0d: got %h c=%b z=%b lat=%0d busy_ok=%b want %h c=%b z=%b lat=9",
                         i, result, carry_out, zero, lat, bok, exp_r[i], i[0], exp_r[i] == 8'h00);
            end
`ifdef SERIAL_ALU_OVF_EN
            checks++;
            if (overflow !== 1'b0) begin errors++; $display("FAIL logic_ovf%0d: got %b want 0", i, overflow); end
`endif
        end
    endtask

    task automatic test_w1();
        int lat = 0;
        @(posedge clk); #1;
        s1_a = 1'b1; s1_b = 1'b1; s1_cin0 = 1'b1; s1_start = 1'b1;
        @(posedge clk); #1;
        s1_start = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (s1_done !== 1'b1 && lat < 20);
        checks++;
        if ({s1_result, s1_carry_out, s1_zero} !== 3'b110 || lat != 2) begin
            errors++;
            $display("FAIL w1_add: got r=%b c=%b z=%b lat=%0d want r=1 c=1 z=0 lat=2",
                     s1_result, s1_carry_out, s1_zero, lat);
        end
        @(negedge clk);
        checks++;
        if ({s1_done, s1_busy, s1_result} !== 3'b001) begin
            errors++; $display("FAIL w1_after: done=%b busy=%b r=%b want 0 0 1", s1_done, s1_busy, s1_result);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap();
        test_arith();
        test_busy_reject();
        test_reset_mid();
        test_logic_sweep();
        test_w1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
